uart_rx: RTL and testbench

//  Receive side of the UART: samples the asynchronous serial line, finds the start bit,

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings for tx/rx and a constant-foldable clog2.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE      = 3'd0,
    s_START     = 3'd1,
    s_DATA      = 3'd2,
    s_STOP      = 3'd3,
    s_WAIT_HIGH = 3'd4
  } uart_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], i_d};
    end
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start, p_WORD_LEN+1 data bits (LSB first) and stop.
// Define UART_RX_PARITY_EN to treat the top data bit as even parity and report o_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned p_CLK_DIV  = 16,
  parameter int unsigned p_WORD_LEN = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic [p_WORD_LEN:0]   o_data,
  output logic                  o_dv,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_active
);

  localparam int unsigned CntW = clog2(p_CLK_DIV) + 1;
  localparam int unsigned BitW = clog2(p_WORD_LEN) + 1;

  localparam logic [CntW-1:0] HalfLast = CntW'(p_CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(p_CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(p_WORD_LEN);

  logic rx_s;

  uart_state_e           state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [p_WORD_LEN:0]   r_data_q, r_data_d;
  logic [p_WORD_LEN:0]   data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  ferr_q, ferr_d;
  logic                  active_q, active_d;

  uart_sync2 #(
    .ResetVal (1'b1)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic parity_bad;

  // Even parity across the whole word: an odd count of ones is an error.
  assign parity_bad = r_data_q[p_WORD_LEN] ^ (^r_data_q[p_WORD_LEN-1:0]);
`endif

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    r_data_d  = r_data_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    active_d  = active_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
`endif

    case (state_q)
      s_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) state_d = s_START;
      end

      s_START: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = s_DATA;
          end else begin
            state_d  = s_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      s_DATA: begin
        if (clk_cnt_q == FullLast) begin
          clk_cnt_d           = '0;
          r_data_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == BitLast) begin
            state_d = s_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      s_STOP: begin
        if (clk_cnt_q == FullLast) begin
          clk_cnt_d = '0;
          active_d  = 1'b0;
          if (rx_s) begin
            data_d  = r_data_q;
            dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = parity_bad;
`endif
            state_d = s_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Line held low after a bad stop bit: wait for idle before hunting for a start.
      s_WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = s_IDLE;
      end

      default: begin
        state_d   = s_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        active_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= s_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      r_data_q  <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      r_data_q  <= r_data_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = data_q;
  assign o_dv        = dv_q;
  assign o_frame_err = ferr_q;
  assign o_active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (p_CLK_DIV=16, p_WORD_LEN=8).
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [8:0] data;
  logic       dv;
  logic       frame_err;
  logic       parity_err;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cyc = 0;
  int ferr_cnt = 0;
  int stray_perr = 0;
  bit active_seen = 1'b0;

  logic [8:0] rx_words[$];
  bit         rx_perr[$];

  uart_rx #(
    .p_CLK_DIV  (16),
    .p_WORD_LEN (8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .o_data       (data),
    .o_dv         (dv),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err),
    .o_active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv) begin
      rx_words.push_back(data);
      rx_perr.push_back(parity_err);
      dv_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (parity_err && !dv) stray_perr++;
    if (active) active_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_perr(input logic [8:0] w);
`ifdef UART_RX_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stretch adds one clock to every even-indexed bit: a transmitter ~3% slow.
  task automatic send_frame(input logic [8:0] word, input logic stop_bit, input bit stretch);
    logic [10:0] bits;
    bits = {stop_bit, word, 1'b0};
    for (int j = 0; j < 11; j++) begin
      rx = bits[j];
      if (j == 0) start_cyc = cyc;
      repeat (16 + ((stretch && (j % 2 == 0)) ? 1 : 0)) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_rx(input string tag, input logic [8:0] word);
    check_eq({tag, "_count"}, rx_words.size(), 1);
    if (rx_words.size() > 0) begin
      check_eq({tag, "_data"}, {23'd0, rx_words[0]}, {23'd0, word});
      check_eq({tag, "_perr"}, {31'd0, rx_perr[0]}, {31'd0, exp_perr(word)});
    end
    check_eq({tag, "_hold"}, {23'd0, data}, {23'd0, word});
    rx_words.delete();
    rx_perr.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", {23'd0, data}, 32'd0);
    check_eq("rst_dv", {31'd0, dv}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_perr", {31'd0, parity_err}, 32'd0);
    check_eq("rst_active", {31'd0, active}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Clean frames, with the latency of the first measured from its falling edge.
    send_frame(9'h0A5, 1'b1, 1'b0);
    check_eq("latency", dv_cyc - start_cyc, 171);
    idle(20);
    check_rx("f0A5", 9'h0A5);
    send_frame(9'h1FF, 1'b1, 1'b0);
    idle(20);
    check_rx("f1FF", 9'h1FF);
    send_frame(9'h000, 1'b1, 1'b0);
    idle(20);
    check_rx("f000", 9'h000);
    check_eq("clean_ferr", ferr_cnt, 0);

    // Short low glitch must not start a frame.
    active_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check_eq("glitch_dv", rx_words.size(), 0);
    check_eq("glitch_active", {31'd0, active_seen}, 32'd0);

    // Bad stop bit, line held low, then a clean frame.
    send_frame(9'h055, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("brk_active", {31'd0, active}, 32'd0);
    idle(20);
    check_eq("brk_ferr", ferr_cnt, 1);
    check_eq("brk_dv", rx_words.size(), 0);
    check_eq("brk_hold", {23'd0, data}, 32'h000);
    send_frame(9'h033, 1'b1, 1'b0);
    idle(20);
    check_rx("f033", 9'h033);

    // Two back-to-back frames from a slightly slow transmitter.
    send_frame(9'h1C6, 1'b1, 1'b1);
    send_frame(9'h039, 1'b1, 1'b1);
    idle(20);
    check_eq("skew_count", rx_words.size(), 2);
    if (rx_words.size() == 2) begin
      check_eq("skew_data0", {23'd0, rx_words[0]}, 32'h1C6);
      check_eq("skew_data1", {23'd0, rx_words[1]}, 32'h039);
      check_eq("skew_perr0", {31'd0, rx_perr[0]}, {31'd0, exp_perr(9'h1C6)});
      check_eq("skew_perr1", {31'd0, rx_perr[1]}, {31'd0, exp_perr(9'h039)});
    end
    rx_words.delete();
    rx_perr.delete();
    check_eq("skew_ferr", ferr_cnt, 1);

    // Reset asserted while data bit 4 is being received.
    fork
      send_frame(9'h1AA, 1'b1, 1'b0);
      begin
        repeat (82) @(posedge clk);
        #3;
        check_eq("mid_active", {31'd0, active}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_active", {31'd0, active}, 32'd0);
        check_eq("mid_rst_data", {23'd0, data}, 32'd0);
        check_eq("mid_rst_dv", {31'd0, dv}, 32'd0);
      end
    join
    idle(5);
    rst_n = 1'b1;
    idle(10);
    check_eq("mid_rst_nodv", rx_words.size(), 0);
    send_frame(9'h0C3, 1'b1, 1'b0);
    idle(20);
    check_rx("f0C3", 9'h0C3);

`ifdef UART_RX_PARITY_EN
    send_frame(9'h001, 1'b1, 1'b0);
    idle(20);
    check_rx("par_bad", 9'h001);
    send_frame(9'h003, 1'b1, 1'b0);
    idle(20);
    check_rx("par_good", 9'h003);
`endif

    check_eq("final_ferr", ferr_cnt, 1);
    check_eq("stray_perr", stray_perr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
